burst_data_buffer: RTL and testbench
====================================

Name: burst_data_buffer

Overview:
- Parametrised successor of the 32-bit, 4-deep SDRAM data buffer.
- Bidirectional FIFO between the SDRAM chip interface and the bus interface. Direction is selected per transaction: read mode moves chip to bus, write mode moves bus to chip.
- Adds generic width and depth, fill count, almost-full/almost-empty thresholds, sticky overflow/underflow flags and a burst-complete pulse.
- Sits between the SDRAM controller FSM and the bus slave.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- BURST_LEN, 4, pops per burst used to generate burst_done.
- AF_LVL, DEPTH-1, almost_full asserts when count >= AF_LVL.
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- r_enable  in  1  one-cycle pulse: start read transaction (chip to bus).
- w_enable  in  1  one-cycle pulse: start write transaction (bus to chip).
- chip  in  1  chip-side strobe: push in read mode, pop in write mode.
- bus  in  1  bus-side strobe: push in write mode, pop in read mode.
- c_rdata  in  DATA_WIDTH  read data from SDRAM.
- b_wdata  in  DATA_WIDTH  write data from bus.
- b_rdata  out  DATA_WIDTH  registered read data to bus.
- c_wdata  out  DATA_WIDTH  registered write data to SDRAM.
- count  out  $clog2(DEPTH+1)  current fill level.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LVL.
- almost_empty  out  1  count <= AE_LVL.
- overflow  out  1  sticky: push attempted while full with no pop.
- underflow  out  1  sticky: pop attempted while empty.
- burst_done  out  1  one-cycle pulse after every BURST_LEN-th successful pop.

Behaviour:
- Reset (async, n_rst=0):
  - state IDLE, pointers 0, count 0.
  - b_rdata=0, c_wdata=0.
  - empty=1, almost_empty=1.
  - full, almost_full, overflow, underflow, burst_done = 0.
- States:
  - IDLE: chip/bus ignored. r_enable goes to READ, w_enable goes to WRITE.
  - READ: push = chip, data c_rdata; pop = bus, output b_rdata.
  - WRITE: push = bus, data b_wdata; pop = chip, output c_wdata.
- Mode entry (r_enable or w_enable sampled high, from any state):
  - Flush at that edge: pointers, count, overflow, underflow and burst counter cleared.
  - b_rdata and c_wdata cleared to 0.
  - chip/bus strobes in the same cycle are ignored.
  - If both enables are high, r_enable wins.
  - Mode persists until the next enable pulse; there is no return to IDLE except by reset.
- Push: accepted if not full, or if full with an accepted pop in the same cycle. The word is written at the tail; visible at the head order after the edge.
- Pop: accepted if not empty. The head word is loaded into the active output register at the edge, so data appears one cycle after the strobe. The inactive output register holds its value. A pop on empty leaves the output unchanged and sets underflow.
- Simultaneous push and pop when not empty: both occur and count is unchanged.
- Simultaneous push and pop when empty: push stored, pop rejected with underflow (see Optional Feature). Count becomes 1.
- Overflow: push while full with no pop drops the word; count unchanged; overflow set.
- Pointers wrap modulo DEPTH.
- count, full, empty, almost_full and almost_empty are registered, consistent with the post-edge count. No combinational path from strobes to flags.
- burst_done:
  - Internal pop counter increments on each accepted pop.
  - On reaching BURST_LEN it wraps to 0 and burst_done is high for the following cycle.

Optional Feature:
- Macro: BURST_DATA_BUFFER_CUT_THROUGH_EN.
- Defined: a push and pop in the same cycle while empty passes the incoming word directly into the active output register. count stays 0, no underflow, and the pop counts toward burst_done.
- Undefined: behaviour as in the Behaviour section (push stored, underflow set).

Test Plan:
- DEPTH=4, BURST_LEN=4. Reset, r_enable pulse, chip=1 with c_rdata 1,2,3,4 over 4 cycles. Required: full=1, count=4. Then bus=1 for 4 cycles: b_rdata 1,2,3,4 on successive cycles, empty=1 after the last pop, burst_done pulses once.
- DEPTH=4. w_enable, then bus=1 with b_wdata 1..5 while chip=1 starts one cycle later. Required: c_wdata 1..5 in order, no overflow, empty=1 at end, count never exceeds 2.
- DEPTH=4. Read mode, push 5 words (10..14) with no pop. Required: overflow=1, count=4, pops return 10..13. A subsequent w_enable clears overflow, count=0, b_rdata=0.
- Write mode, chip=1 while empty. Required: underflow=1, c_wdata unchanged (0).
- Same-cycle push and pop on empty, data 0xA5, macro undefined: count=1, underflow=1. With the macro defined: c_wdata=0xA5 next cycle, count=0, underflow=0.
- Assert n_rst mid-burst (count=3, READ). Required: immediately count=0, empty=1, b_rdata=0, state IDLE; chip/bus ignored until the next enable pulse.

Source files
------------

// File: rtl/burst_data_buffer.sv
// Bidirectional SDRAM/bus FIFO; direction chosen per transaction; BURST_DATA_BUFFER_CUT_THROUGH_EN enables empty-FIFO bypass.
// Latency: pushed word poppable the cycle after the push; popped word appears in the output register one cycle after the strobe.
// Backpressure: none; push on full (no pop) is dropped and flags overflow, pop on empty is refused and flags underflow.
module burst_data_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int BURST_LEN  = 4,
   parameter int AF_LVL     = DEPTH - 1,
   parameter int AE_LVL     = 1
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         r_enable,
   input  logic                         w_enable,
   input  logic                         chip,
   input  logic                         bus,
   input  logic [DATA_WIDTH-1:0]        c_rdata,
   input  logic [DATA_WIDTH-1:0]        b_wdata,
   output logic [DATA_WIDTH-1:0]        b_rdata,
   output logic [DATA_WIDTH-1:0]        c_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         overflow,
   output logic                         underflow,
   output logic                         burst_done
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(BURST_LEN) + 1;
   localparam logic [BW-1:0] BLAST = BW'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t                state, state_nxt;
   logic                  mode_entry;
   logic                  push_req, pop_req, push_ok, pop_ok, pop_any, cut;
   logic [DATA_WIDTH-1:0] push_dat, out_dat;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [BW-1:0]         bcnt;

   assign mode_entry = r_enable | w_enable;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (r_enable)      state_nxt = READ;
      else if (w_enable) state_nxt = WRITE;
   end

   // Strobes seen in the same cycle as a mode-entry pulse belong to the old transaction and are dropped.
   always_comb begin
      push_req = 1'b0;
      pop_req  = 1'b0;
      push_dat = c_rdata;
      if (!mode_entry) begin
         case (state)
            READ: begin
               push_req = chip;
               pop_req  = bus;
               push_dat = c_rdata;
            end
            WRITE: begin
               push_req = bus;
               pop_req  = chip;
               push_dat = b_wdata;
            end
            default: ;
         endcase
      end
   end

`ifdef BURST_DATA_BUFFER_CUT_THROUGH_EN
   assign cut = push_req & pop_req & empty;
`else
   assign cut = 1'b0;
`endif

   assign pop_ok  = pop_req & ~empty;
   assign push_ok = push_req & ~cut & (~full | pop_ok);
   assign pop_any = pop_ok | cut;
   assign out_dat = cut ? push_dat : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         bcnt       <= '0;
         burst_done <= 1'b0;
         b_rdata    <= '0;
         c_wdata    <= '0;
      end else if (mode_entry) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
         bcnt       <= '0;
         burst_done <= 1'b0;
         b_rdata    <= '0;
         c_wdata    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push_req && full && !pop_ok) overflow  <= 1'b1;
         if (pop_req && empty && !cut)    underflow <= 1'b1;
         burst_done <= 1'b0;
         if (pop_any) begin
            if (bcnt == BLAST) begin
               bcnt       <= '0;
               burst_done <= 1'b1;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
            if (state == READ) b_rdata <= out_dat;
            else               c_wdata <= out_dat;
         end
      end
   end

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LVL));
   assign almost_empty = (count <= CW'(AE_LVL));

endmodule

// File: tb/tb_burst_data_buffer.sv
// Directed bench for burst_data_buffer (DEPTH=4, BURST_LEN=4) against a queue-based model.
module tb_burst_data_buffer;

   localparam int DEPTH = 4;
   localparam int BLEN  = 4;
   localparam int AFL   = DEPTH - 1;
   localparam int AEL   = 1;

   logic        clk = 1'b0;
   logic        n_rst, r_enable, w_enable, chip, bus;
   logic [31:0] c_rdata, b_wdata, b_rdata, c_wdata;
   logic [2:0]  count;
   logic        full, empty, almost_full, almost_empty, overflow, underflow, burst_done;

   burst_data_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH), .BURST_LEN(BLEN)) dut (
      .clk(clk), .n_rst(n_rst), .r_enable(r_enable), .w_enable(w_enable),
      .chip(chip), .bus(bus), .c_rdata(c_rdata), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .c_wdata(c_wdata), .count(count), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Model: mode 0 idle, 1 read (chip->bus), 2 write (bus->chip)
   int          m_mode;
   logic [31:0] q[$];
   logic [31:0] m_b, m_c;
   bit          m_ovf, m_udf, m_bd;
   int          m_bcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; q = {}; m_b = 0; m_c = 0;
      m_ovf = 0; m_udf = 0; m_bd = 0; m_bcnt = 0;
   endtask

   task automatic model_out(input logic [31:0] v);
      if (m_mode == 1) m_b = v; else m_c = v;
      m_bcnt++;
      if (m_bcnt == BLEN) begin
         m_bcnt = 0;
         m_bd   = 1;
      end
   endtask

   task automatic model_step();
      bit psh, pp, popped, ct;
      logic [31:0] din;
      if (!n_rst) begin
         model_reset();
      end else if (r_enable || w_enable) begin
         model_reset();
         m_mode = r_enable ? 1 : 2;
      end else begin
         m_bd = 0;
         psh  = (m_mode == 1) ? chip : (m_mode == 2) ? bus  : 1'b0;
         pp   = (m_mode == 1) ? bus  : (m_mode == 2) ? chip : 1'b0;
         din  = (m_mode == 1) ? c_rdata : b_wdata;
         ct   = 0;
`ifdef BURST_DATA_BUFFER_CUT_THROUGH_EN
         ct = psh && pp && (q.size() == 0);
`endif
         if (ct) begin
            model_out(din);
         end else begin
            popped = 0;
            if (pp) begin
               if (q.size() > 0) begin
                  model_out(q.pop_front());
                  popped = 1;
               end else begin
                  m_udf = 1;
               end
            end
            if (psh) begin
               if (q.size() < DEPTH) q.push_back(din);
               else if (!popped) m_ovf = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      chk("b_rdata", b_rdata, m_b);
      chk("c_wdata", c_wdata, m_c);
      chk("count", 32'(count), 32'(n));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= AFL));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AEL));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("burst_done", 32'(burst_done), 32'(m_bd));
   endtask

   task automatic cycle(input logic re, input logic we, input logic ch, input logic bs,
                        input logic [31:0] cd, input logic [31:0] bd);
      r_enable = re; w_enable = we; chip = ch; bus = bs; c_rdata = cd; b_wdata = bd;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   int maxc;

   initial begin
      n_rst = 0; r_enable = 0; w_enable = 0; chip = 0; bus = 0; c_rdata = 0; b_wdata = 0;
      model_reset();
      #1;
      cycle(0, 0, 0, 0, 0, 0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_brdata", b_rdata, 32'd0);
      n_rst = 1;
      cycle(0, 0, 1, 1, 32'h77, 32'h88);      // idle: strobes ignored
      chk("idle_count", 32'(count), 32'd0);

      // Read burst: fill 1..4, drain 1..4
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) cycle(0, 0, 1, 0, 32'(k), 0);
      chk("t1_full", 32'(full), 32'd1);
      chk("t1_count", 32'(count), 32'd4);
      for (int k = 1; k <= 4; k++) begin
         cycle(0, 0, 0, 1, 0, 0);
         chk("t1_brdata", b_rdata, 32'(k));
      end
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_burst_done", 32'(burst_done), 32'd1);
      cycle(0, 0, 0, 0, 0, 0);
      chk("t1_burst_done_pulse", 32'(burst_done), 32'd0);

      // Write streaming: pop lags push by one cycle
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 32'd1);
      maxc = int'(count);
      for (int k = 2; k <= 5; k++) begin
         cycle(0, 0, 1, 1, 0, 32'(k));
         chk("t2_cwdata", c_wdata, 32'(k - 1));
         if (int'(count) > maxc) maxc = int'(count);
      end
      cycle(0, 0, 1, 0, 0, 0);
      chk("t2_cwdata_last", c_wdata, 32'd5);
      chk("t2_empty", 32'(empty), 32'd1);
      chk("t2_no_ovf", 32'(overflow), 32'd0);
      chk("t2_max_count_le2", 32'(maxc <= 2), 32'd1);

      // Overflow in read mode
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 10; k <= 14; k++) cycle(0, 0, 1, 0, 32'(k), 0);
      chk("t3_ovf", 32'(overflow), 32'd1);
      chk("t3_count", 32'(count), 32'd4);
      for (int k = 10; k <= 13; k++) begin
         cycle(0, 0, 0, 1, 0, 0);
         chk("t3_brdata", b_rdata, 32'(k));
      end
      cycle(0, 1, 0, 0, 0, 0);
      chk("t3_ovf_clr", 32'(overflow), 32'd0);
      chk("t3_count_clr", 32'(count), 32'd0);
      chk("t3_brdata_clr", b_rdata, 32'd0);

      // Underflow in write mode
      cycle(0, 0, 1, 0, 0, 0);
      chk("t4_udf", 32'(underflow), 32'd1);
      chk("t4_cwdata", c_wdata, 32'd0);

      // Same-cycle push/pop on empty
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 1, 0, 32'hA5);
`ifdef BURST_DATA_BUFFER_CUT_THROUGH_EN
      chk("t5_cwdata", c_wdata, 32'hA5);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_udf", 32'(underflow), 32'd0);
`else
      chk("t5_cwdata", c_wdata, 32'd0);
      chk("t5_count", 32'(count), 32'd1);
      chk("t5_udf", 32'(underflow), 32'd1);
`endif

      // Asynchronous reset mid-burst
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 3; k++) cycle(0, 0, 1, 0, 32'(20 + k), 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 32'd30, 0);
      chk("t6_count_pre", 32'(count), 32'd3);
      #2;
      n_rst = 0;
      model_reset();
      #1;
      chk("t6_count_rst", 32'(count), 32'd0);
      chk("t6_empty_rst", 32'(empty), 32'd1);
      chk("t6_brdata_rst", b_rdata, 32'd0);
      cycle(0, 0, 1, 1, 32'h55, 32'h66);
      n_rst = 1;
      cycle(0, 0, 1, 1, 32'h55, 32'h66);
      cycle(0, 0, 1, 0, 32'h57, 32'h66);
      chk("t6_idle_count", 32'(count), 32'd0);
      chk("t6_idle_brdata", b_rdata, 32'd0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 32'h99, 0);
      cycle(0, 0, 0, 1, 0, 0);
      chk("t6_resume_brdata", b_rdata, 32'h99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
